// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a multi-cycle MIPS-like core.
//
// Each instruction takes one FETCH cycle (waiting for imem_ack) and at least
// one EXEC cycle. In EXEC the control inputs select the next pc. A jr to a
// misaligned target freezes the sequencer in HALT until reset.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ext_imm      in   [31:0] sign-extended branch immediate
//   jump_target  in   [25:0] j/jal target field
//   reg_target   in   [31:0] rs value for jr
//   branch       in   beq-class branch
//   alu_zero     in   ALU zero flag (branch taken when branch & alu_zero)
//   jump         in   j/jal
//   jr           in   jr
//   stall        in   hold pc in EXEC this cycle
//   imem_ack     in   instruction memory has the instruction for pc
//   pc           out  [31:0] current program counter
//   pc_plus4     out  [31:0] pc + 4 (combinational, jal link value)
//   imem_req     out  fetch request for address pc
//   instr_valid  out  instruction executing; controls sampled this cycle
//   halted       out  sticky misaligned-jr fault
//   state_dbg    out  [1:0] FSM state (0 FETCH, 1 EXEC, 2 HALT)
//
// Handshake: in FETCH imem_req is held high until a cycle with imem_ack=1;
// that cycle completes the fetch and the next cycle is EXEC. imem_ack seen in
// any other state has no effect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ext_imm,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        jump,
  input  logic        jr,
  input  logic        stall,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign pc_plus4  = pc + 32'd4;
  assign state_dbg = state;

  assign jr_misaligned = jr && (reg_target[1:0] != 2'b00);

  // jr beats jump beats taken branch beats fall-through; all adds wrap.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = reg_target;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch && alu_zero) begin
      next_pc = pc_plus4 + {ext_imm[29:0], 2'b00};
    end
  end

  // imem_req / instr_valid / halted are registered alongside the state so
  // they always match it; the reset value of imem_req reflects FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            state       <= EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            if (jr_misaligned) begin
              // pc stays on the faulting instruction for inspection.
              state       <= HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              pc          <= next_pc;
              state       <= FETCH;
              imem_req    <= 1'b1;
              instr_valid <= 1'b0;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          state       <= HALT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed testbench for pc_sequencer (RESET_PC = 0).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] ext_imm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        branch;
  logic        alu_zero;
  logic        jump;
  logic        jr;
  logic        stall;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ext_imm(ext_imm), .jump_target(jump_target),
    .reg_target(reg_target), .branch(branch), .alu_zero(alu_zero),
    .jump(jump), .jr(jr), .stall(stall), .imem_ack(imem_ack), .pc(pc),
    .pc_plus4(pc_plus4), .imem_req(imem_req), .instr_valid(instr_valid),
    .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_controls();
    branch = 0; alu_zero = 0; jump = 0; jr = 0; stall = 0;
    ext_imm = '0; jump_target = '0; reg_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // ---------------- drivers ----------------
  // Wait (bounded) until the DUT is in EXEC; an expired bound is a failure.
  task automatic wait_exec();
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL wait_exec: instr_valid=%b after %0d cycles, want 1", instr_valid, n);
    end
  endtask

  // Run one non-stalled instruction with the given controls.
  task automatic exec_instr(input logic br, input logic az, input logic jp,
                            input logic jrr, input logic [31:0] imm,
                            input logic [25:0] jt, input logic [31:0] rt);
    imem_ack = 1;
    wait_exec();
    branch = br; alu_zero = az; jump = jp; jr = jrr;
    ext_imm = imm; jump_target = jt; reg_target = rt;
    step();
    clear_controls();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1;
    imem_ack = 0;
    clear_controls();
    step();
    #2 rst_n = 0;
    #1;
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_flags: iv=%b halted=%b want 0 0", instr_valid, halted);
    end
    step();
    rst_n = 1;
    total++;
    if (imem_req !== 1'b1 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL reset_release: imem_req=%b state=%0d want 1 0", imem_req, state_dbg);
    end
  endtask

  task automatic test_sequential();
    rst_n = 0;
    imem_ack = 1;
    step();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (pc !== 32'(4 * (i / 2)) || instr_valid !== 1'(i % 2)) begin
        bad++;
        $display("FAIL seq[%0d]: pc=%h iv=%b want pc=%h iv=%b", i, pc, instr_valid,
                 32'(4 * (i / 2)), 1'(i % 2));
      end
      step();
    end
  endtask

  task automatic test_branch();
    exec_instr(0, 0, 0, 1, 0, 0, 32'h100);
    exec_instr(1, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
    total++;
    if (pc !== 32'h0FC) begin bad++; $display("FAIL branch_taken: got %h want %h", pc, 32'h0FC); end
    exec_instr(0, 0, 0, 1, 0, 0, 32'h100);
    exec_instr(1, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    total++;
    if (pc !== 32'h104) begin bad++; $display("FAIL branch_not_taken: got %h want %h", pc, 32'h104); end
    exec_instr(0, 1, 0, 0, 32'h0000_0010, 0, 0);
    total++;
    if (pc !== 32'h108) begin bad++; $display("FAIL zero_no_branch: got %h want %h", pc, 32'h108); end
  endtask

  task automatic test_jump();
    exec_instr(0, 0, 0, 1, 0, 0, 32'h4000_0010);
    exec_instr(0, 0, 1, 0, 0, 26'h0000040, 0);
    total++;
    if (pc !== 32'h4000_0100) begin bad++; $display("FAIL jump: got %h want %h", pc, 32'h4000_0100); end
    exec_instr(0, 0, 0, 1, 0, 0, 32'h4000_0010);
    exec_instr(1, 1, 1, 1, 32'h8, 26'h0000040, 32'h200);
    total++;
    if (pc !== 32'h200) begin bad++; $display("FAIL jr_priority: got %h want %h", pc, 32'h200); end
  endtask

  task automatic test_wrap();
    exec_instr(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
    total++;
    if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL pc_plus4_wrap: got %h want %h", pc_plus4, 32'h0); end
    exec_instr(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL pc_wrap: got %h want %h", pc, 32'h0); end
    exec_instr(1, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
    total++;
    if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL neg_wrap: got %h want %h", pc, 32'hFFFF_FFFC); end
  endtask

  task automatic test_ack_stall();
    // pc is 0xFFFF_FFFC in FETCH here.
    imem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'hFFFF_FFFC) begin
        bad++;
        $display("FAIL ack_wait[%0d]: req=%b iv=%b pc=%h want 1 0 fffffffc", i, imem_req, instr_valid, pc);
      end
    end
    imem_ack = 1;
    step();
    imem_ack = 0;
    total++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++; $display("FAIL ack_exec: iv=%b req=%b want 1 0", instr_valid, imem_req);
    end
    stall = 1;
    jump = 1; jump_target = 26'h0000123;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC) begin
        bad++; $display("FAIL stall[%0d]: iv=%b pc=%h want 1 fffffffc", i, instr_valid, pc);
      end
    end
    stall = 0;
    step();
    clear_controls();
    // {pc_plus4[31:28]=0, 0x123, 00}
    total++;
    if (pc !== 32'h0000_048C || imem_req !== 1'b1) begin
      bad++; $display("FAIL stall_release: pc=%h req=%b want 0000048c 1", pc, imem_req);
    end
    step();
    total++;
    if (pc !== 32'h0000_048C) begin bad++; $display("FAIL single_update: got %h want %h", pc, 32'h48C); end
  endtask

  task automatic test_halt();
    logic [31:0] held_pc;
    imem_ack = 1;
    wait_exec();
    held_pc = pc;
    jr = 1; reg_target = 32'h202; stall = 1;
    step();
    step();
    total++;
    if (halted !== 1'b0 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL halt_stalled: halted=%b iv=%b want 0 1", halted, instr_valid);
    end
    stall = 0;
    step();
    clear_controls();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          pc !== held_pc || state_dbg !== 2'd2) begin
        bad++;
        $display("FAIL halt[%0d]: halted=%b req=%b iv=%b pc=%h st=%0d want 1 0 0 %h 2",
                 i, halted, imem_req, instr_valid, pc, state_dbg, held_pc);
      end
      step();
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (pc !== 32'h0 || halted !== 1'b0) begin
      bad++; $display("FAIL halt_reset: pc=%h halted=%b want 0 0", pc, halted);
    end
    step();
    rst_n = 1;
    total++;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL halt_release: req=%b want 1", imem_req); end
  endtask

  task automatic test_reset_mid_exec();
    exec_instr(0, 0, 0, 1, 0, 0, 32'h300);
    imem_ack = 1;
    wait_exec();
    jump = 1; jump_target = 26'h0000200;
    #2 rst_n = 0;
    step();
    step();
    clear_controls();
    rst_n = 1;
    total++;
    if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL reset_mid_exec: pc=%h iv=%b req=%b want 0 0 1", pc, instr_valid, imem_req);
    end
    step();
    total++;
    if (pc !== 32'h0 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL after_reset_fetch: pc=%h iv=%b want 0 1", pc, instr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_ack_stall();
    test_halt();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ext_imm  input  32  sign-extended 16-bit immediate from the sign-extension stage.
REQ-005 SHALL have port jump_target  input  26  instruction bits [25:0] for j/jal.
REQ-006 SHALL have port reg_target  input  32  rs register value for jr.
REQ-007 SHALL have port branch  input  1  current instruction is beq-class branch.
REQ-008 SHALL have port alu_zero  input  1  ALU zero flag; branch taken when branch and alu_zero both 1.
REQ-009 SHALL have port jump  input  1  current instruction is j/jal.
REQ-010 SHALL have port jr  input  1  current instruction is jr.
REQ-011 SHALL have port stall  input  1  hold PC in EXEC for this cycle.
REQ-012 SHALL have port imem_ack  input  1  instruction memory has instruction for pc.
REQ-013 SHALL have port pc  output  32  current program counter.
REQ-014 SHALL have port pc_plus4  output  32  pc + 4, combinational, for jal link.
REQ-015 SHALL have port imem_req  output  1  fetch request for address pc.
REQ-016 SHALL have port instr_valid  output  1  instruction executing; control inputs sampled this cycle.
REQ-017 SHALL have port halted  output  1  sticky misaligned-jr fault.

Function
REQ-018 SHALL implement states FETCH, EXEC, HALT; encoding free.
REQ-019 FETCH: imem_req=1, instr_valid=0; on imem_ack=1 go to EXEC next cycle; else stay.
REQ-020 EXEC: imem_req=0, instr_valid=1; control inputs (branch, alu_zero, jump, jr, ext_imm, jump_target, reg_target) sampled only in EXEC.
REQ-021 EXEC with stall=1: pc unchanged, stay in EXEC.
REQ-022 EXEC with stall=0: pc <= next_pc, go to FETCH; one instruction = minimum 2 cycles.
REQ-023 next_pc priority: jr -> reg_target; else jump -> {pc_plus4[31:28], jump_target, 2'b00}; else branch&alu_zero -> pc_plus4 + (ext_imm << 2); else pc_plus4.
REQ-024 all adds SHALL be 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0; negative ext_imm wraps below 0 likewise.
REQ-025 branch with alu_zero=0 SHALL select pc_plus4; alu_zero ignored when branch=0.
REQ-026 jr with reg_target[1:0] != 0 in EXEC with stall=0: pc unchanged, halted <= 1, go to HALT.
REQ-027 jr with misaligned target and stall=1: no fault until stall deasserts.
REQ-028 HALT: imem_req=0, instr_valid=0, halted=1, pc frozen; exits only via reset.
REQ-029 imem_ack outside FETCH SHALL be ignored.
REQ-030 pc[1:0] SHALL always be 2'b00 while not in reset with aligned RESET_PC.

Reset
REQ-031 rst_n=0 SHALL asynchronously force pc=RESET_PC, state=FETCH, halted=0, instr_valid=0; imem_req=1 on first cycle after release.
REQ-032 reset mid-EXEC or mid-HALT SHALL abandon pending update; no next_pc write after release.

Verification
REQ-033 reset, imem_ack=1 constant, no controls -> pc 0,4,8,C every 2 cycles, instr_valid alternating 0/1.
REQ-034 pc=0x100, branch=1, alu_zero=1, ext_imm=0xFFFF_FFFE -> next pc 0x0FC; same with alu_zero=0 -> 0x104.
REQ-035 pc=0x4000_0010, jump=1, jump_target=0x0000040 -> pc 0x4000_0100; jr=1 also set with reg_target=0x200 -> pc 0x200.
REQ-036 imem_ack held 0 for 5 cycles then 1 -> imem_req stays 1, pc stable, EXEC on the cycle after ack; stall=1 for 3 EXEC cycles -> pc held, single update after release.
REQ-037 jr=1, reg_target=0x202 -> halted=1, pc unchanged, imem_req=0 forever; rst_n pulse low -> pc=RESET_PC, halted=0.
REQ-038 pc=0xFFFF_FFFC, no controls -> next pc 0x0000_0000.
